// File: rtl/data_mem_resp_pkg.sv
// Shared definitions for the data-memory responder: bus widths, lane geometry,
// FSM state encodings and the latched request record.
package data_mem_resp_pkg;

    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;
    localparam int LANE_W     = 8;
    localparam int NUM_LANES  = BUS_DATA_W / LANE_W;
    localparam int CNT_W      = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef struct packed {
        logic                  we;
        logic [NUM_LANES-1:0]  sel;
        logic [BUS_ADDR_W-1:0] adr;
        logic [BUS_DATA_W-1:0] dat;
    } req_t;

    // Expands byte-lane selects to a bit mask; sel[3] covers bits 31:24.
    function automatic logic [BUS_DATA_W-1:0] lane_mask(input logic [NUM_LANES-1:0] sel);
        logic [BUS_DATA_W-1:0] mask;
        mask = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            mask[i*LANE_W +: LANE_W] = {LANE_W{sel[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/data_mem_resp_dmem_ram.sv
// Word-addressed data store built from byte-wide banks: synchronous per-lane
// write, combinational read. Contents are never reset.
module dmem_ram
    import data_mem_resp_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                  clk,
    input  logic [NUM_LANES-1:0]  we_i,
    input  logic [ADDR_W-1:0]     waddr_i,
    input  logic [BUS_DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0]     raddr_i,
    output logic [BUS_DATA_W-1:0] rdata_o
);

    for (genvar lane = 0; lane < NUM_LANES; lane++) begin : g_bank
        logic [LANE_W-1:0] bank_q [2**ADDR_W];

        always_ff @(posedge clk) begin
            if (we_i[lane]) begin
                bank_q[waddr_i] <= wdata_i[lane*LANE_W +: LANE_W];
            end
        end

        assign rdata_o[lane*LANE_W +: LANE_W] = bank_q[raddr_i];
    end

endmodule

// File: rtl/data_mem_resp.sv
// Memory-stage data responder: latches one bus request, waits WAIT_CYCLES,
// performs the decoded access and returns a single-cycle ack or err.
module data_mem_resp
    import data_mem_resp_pkg::*;
#(
    parameter int                    ADDR_W      = 10,
    parameter int                    WAIT_CYCLES = 1,
    parameter logic [BUS_ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [NUM_LANES-1:0]  sel_i,
    input  logic [BUS_ADDR_W-1:0] adr_i,
    input  logic [BUS_DATA_W-1:0] dat_i,
    output logic [BUS_DATA_W-1:0] dat_o,
    output logic                  ack_o,
    output logic                  err_o,
    output logic [1:0]            dbg_state_o
);

    localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    req_t                  req_q, req_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [BUS_DATA_W-1:0] dat_q, dat_d;

    req_t                  in_req;
    req_t                  wr_src;
    logic                  enter_resp;
    logic                  req_hit;
    logic [NUM_LANES-1:0]  ram_we;
    logic [BUS_DATA_W-1:0] ram_rdata;
    logic                  unused_adr_bits;

    function automatic logic decode_hit(input logic [BUS_ADDR_W-1:0] a);
        return a[BUS_ADDR_W-1:ADDR_W+2] == BASE_ADDR[BUS_ADDR_W-1:ADDR_W+2];
    endfunction

    assign in_req  = '{we: we_i, sel: sel_i, adr: adr_i, dat: dat_i};
    assign req_hit = decode_hit(req_q.adr);

    // With no wait states the write lands on the sampling edge itself, so it
    // must come straight from the bus rather than from the request latch.
    assign wr_src = (state_q == ST_IDLE) ? in_req : req_q;
    assign ram_we = (enter_resp && wr_src.we && decode_hit(wr_src.adr)) ? wr_src.sel : '0;

    assign unused_adr_bits = ^{req_q.adr[1:0], wr_src.adr[1:0]};

    dmem_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (wr_src.adr[ADDR_W+1:2]),
        .wdata_i (wr_src.dat),
        .raddr_i (req_q.adr[ADDR_W+1:2]),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        enter_resp = 1'b0;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        dat_d      = '0;
        case (state_q)
            ST_IDLE: begin
                if (cyc_i && stb_i) begin
                    req_d = in_req;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!cyc_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                // Response is registered here and presented the cycle after RESP.
                state_d = ST_IDLE;
                ack_d   = req_hit;
                err_d   = !req_hit;
                dat_d   = (req_hit && !req_q.we) ? (ram_rdata & lane_mask(req_q.sel)) : '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
        end
    end

    assign ack_o       = ack_q;
    assign err_o       = err_q;
    assign dat_o       = ack_q ? dat_q : '0;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: a zero-wait and a one-wait instance driven with
// directed scenarios and random traffic against a word-level memory model.
module tb_data_mem_resp;
    import data_mem_resp_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cyc [2];
    logic        stb [2];
    logic        we  [2];
    logic [3:0]  sel [2];
    logic [31:0] adr [2];
    logic [31:0] dat_w [2];
    logic [31:0] dat_r [2];
    logic        ack [2];
    logic        err [2];
    logic [1:0]  st  [2];

    data_mem_resp #(.ADDR_W(10), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_dut_w0 (
        .clk(clk), .rst(rst), .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we[0]),
        .sel_i(sel[0]), .adr_i(adr[0]), .dat_i(dat_w[0]), .dat_o(dat_r[0]),
        .ack_o(ack[0]), .err_o(err[0]), .dbg_state_o(st[0])
    );

    data_mem_resp #(.ADDR_W(10), .WAIT_CYCLES(1), .BASE_ADDR(32'h0)) u_dut_w1 (
        .clk(clk), .rst(rst), .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we[1]),
        .sel_i(sel[1]), .adr_i(adr[1]), .dat_i(dat_w[1]), .dat_o(dat_r[1]),
        .ack_o(ack[1]), .err_o(err[1]), .dbg_state_o(st[1])
    );

    int n_checks = 0;
    int n_err    = 0;

    bit          r_ack, r_err, r_single;
    logic [31:0] r_dat;
    int          lat;
    logic [42:0] obs, exp_v;

    // Word-level reference memory, keyed by instance and word index.
    logic [31:0] mem_m [int];

    function automatic int key_of(input int which, input logic [31:0] a);
        return which * 65536 + int'(a[11:2]);
    endfunction

    function automatic bit in_win(input logic [31:0] a);
        return a[31:12] == 20'h0;
    endfunction

    function automatic logic [31:0] byte_mask(input logic [3:0] s);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) if (s[i]) m[i*8 +: 8] = 8'hFF;
        return m;
    endfunction

    // One bus transaction: request held for the sampling edge only, inputs
    // scrambled afterwards, then wait (bounded) for ack/err. lat counts edges
    // after the sampling edge; -1 means no response seen.
    task automatic txn(input int which, input bit w, input logic [3:0] s,
                       input logic [31:0] a, input logic [31:0] d, input bit abort_wait,
                       output bit o_ack, output bit o_err, output logic [31:0] o_dat,
                       output int o_lat, output bit o_single);
        o_ack = 0; o_err = 0; o_dat = '0; o_lat = -1; o_single = 0;
        @(negedge clk);
        cyc[which] = 1'b1; stb[which] = 1'b1; we[which] = w;
        sel[which] = s; adr[which] = a; dat_w[which] = d;
        @(negedge clk);
        stb[which]   = 1'b0;
        cyc[which]   = !abort_wait;
        we[which]    = 1'($urandom);
        sel[which]   = 4'($urandom);
        adr[which]   = $urandom;
        dat_w[which] = $urandom;
        for (int j = 0; j <= 12; j++) begin
            if (ack[which] || err[which]) begin
                o_ack = ack[which]; o_err = err[which]; o_dat = dat_r[which]; o_lat = j;
                break;
            end
            @(negedge clk);
        end
        if (o_lat >= 0) begin
            @(negedge clk);
            o_single = !(ack[which] || err[which]);
        end
        cyc[which] = 1'b0;
        stb[which] = 1'b0;
    endtask

    task test_reset;
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({ack[i], err[i], dat_r[i], st[i]} !== {1'b0, 1'b0, 32'h0, ST_IDLE}) begin
                n_err++;
                $display("FAIL reset_outputs dut%0d: got ack=%b err=%b dat=%h st=%0d want 0 0 0 %0d",
                         i, ack[i], err[i], dat_r[i], st[i], ST_IDLE);
            end
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task test_store_load;
        txn(1, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, 1'b0, r_ack, r_err, r_dat, lat, r_single);
        obs = {r_ack, r_err, r_dat, r_single, 8'(lat)};
        exp_v = {1'b1, 1'b0, 32'h0, 1'b1, 8'd2};
        n_checks++;
        if (obs !== exp_v) begin n_err++; $display("FAIL store_full: got %h want %h", obs, exp_v); end
        txn(1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, r_ack, r_err, r_dat, lat, r_single);
        obs = {r_ack, r_err, r_dat, r_single, 8'(lat)};
        exp_v = {1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 8'd2};
        n_checks++;
        if (obs !== exp_v) begin n_err++; $display("FAIL load_full: got %h want %h", obs, exp_v); end
    endtask

    task test_byte_lanes;
        txn(1, 1'b1, 4'b0100, 32'h10, 32'h0011_2233, 1'b0, r_ack, r_err, r_dat, lat, r_single);
        n_checks++;
        if ({r_ack, r_err} !== 2'b10) begin n_err++; $display("FAIL byte_store_ack: got %b%b want 10", r_ack, r_err); end
        txn(1, 1'b0, 4'hF, 32'h12, 32'h0, 1'b0, r_ack, r_err, r_dat, lat, r_single);
        n_checks++;
        if (r_dat !== 32'hDE11_BEEF) begin n_err++; $display("FAIL byte_merge: got %h want DE11BEEF", r_dat); end
        txn(1, 1'b0, 4'b1010, 32'h10, 32'h0, 1'b0, r_ack, r_err, r_dat, lat, r_single);
        n_checks++;
        if (r_dat !== 32'hDE00_BE00) begin n_err++; $display("FAIL partial_load: got %h want DE00BE00", r_dat); end
        txn(1, 1'b1, 4'b0000, 32'h10, 32'hFFFF_FFFF, 1'b0, r_ack, r_err, r_dat, lat, r_single);
        n_checks++;
        if ({r_ack, r_err} !== 2'b10) begin n_err++; $display("FAIL sel0_ack: got %b%b want 10", r_ack, r_err); end
        txn(1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, r_ack, r_err, r_dat, lat, r_single);
        n_checks++;
        if (r_dat !== 32'hDE11_BEEF) begin n_err++; $display("FAIL sel0_nochange: got %h want DE11BEEF", r_dat); end
    endtask

    task test_decode_err;
        txn(1, 1'b0, 4'hF, 32'h0000_1000, 32'h0, 1'b0, r_ack, r_err, r_dat, lat, r_single);
        obs = {r_ack, r_err, r_dat, r_single, 8'(lat)};
        exp_v = {1'b0, 1'b1, 32'h0, 1'b1, 8'd2};
        n_checks++;
        if (obs !== exp_v) begin n_err++; $display("FAIL err_load: got %h want %h", obs, exp_v); end
        // 0x1010 aliases word 4 (0x10) if the upper bits were not decoded.
        txn(1, 1'b1, 4'hF, 32'h0000_1010, 32'h0BAD_0BAD, 1'b0, r_ack, r_err, r_dat, lat, r_single);
        n_checks++;
        if ({r_ack, r_err} !== 2'b01) begin n_err++; $display("FAIL err_store: got %b%b want 01", r_ack, r_err); end
        txn(1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, r_ack, r_err, r_dat, lat, r_single);
        n_checks++;
        if (r_dat !== 32'hDE11_BEEF) begin n_err++; $display("FAIL err_nowrite: got %h want DE11BEEF", r_dat); end
    endtask

    task test_abort;
        txn(1, 1'b1, 4'hF, 32'h20, 32'h1234_5678, 1'b0, r_ack, r_err, r_dat, lat, r_single);
        txn(1, 1'b1, 4'hF, 32'h20, 32'hCAFE_F00D, 1'b1, r_ack, r_err, r_dat, lat, r_single);
        n_checks++;
        if ({r_ack, r_err, 8'(lat)} !== {2'b00, 8'hFF}) begin
            n_err++; $display("FAIL abort_noresp: got ack=%b err=%b lat=%0d want no response", r_ack, r_err, lat);
        end
        txn(1, 1'b0, 4'hF, 32'h20, 32'h0, 1'b0, r_ack, r_err, r_dat, lat, r_single);
        n_checks++;
        if (r_dat !== 32'h1234_5678) begin n_err++; $display("FAIL abort_nowrite: got %h want 12345678", r_dat); end
    endtask

    task test_reset_mid_wait;
        txn(1, 1'b1, 4'hF, 32'h30, 32'hA5A5_0F0F, 1'b0, r_ack, r_err, r_dat, lat, r_single);
        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; sel[1] = 4'hF;
        adr[1] = 32'h30; dat_w[1] = 32'h1111_2222;
        @(negedge clk);
        stb[1] = 1'b0;
        n_checks++;
        if (st[1] !== ST_WAIT) begin n_err++; $display("FAIL rst_pre_wait: got st=%0d want %0d", st[1], ST_WAIT); end
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if ({ack[1], err[1], dat_r[1], st[1]} !== {2'b00, 32'h0, ST_IDLE}) begin
            n_err++; $display("FAIL rst_mid_wait: got ack=%b err=%b dat=%h st=%0d want 0 0 0 %0d",
                              ack[1], err[1], dat_r[1], st[1], ST_IDLE);
        end
        @(negedge clk);
        cyc[1] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        txn(1, 1'b0, 4'hF, 32'h30, 32'h0, 1'b0, r_ack, r_err, r_dat, lat, r_single);
        n_checks++;
        if (r_dat !== 32'hA5A5_0F0F) begin n_err++; $display("FAIL rst_nowrite: got %h want A5A50F0F", r_dat); end
    endtask

    task test_wait0;
        txn(0, 1'b1, 4'hF, 32'h40, 32'h0BAD_F00D, 1'b0, r_ack, r_err, r_dat, lat, r_single);
        obs = {r_ack, r_err, r_dat, r_single, 8'(lat)};
        exp_v = {1'b1, 1'b0, 32'h0, 1'b1, 8'd1};
        n_checks++;
        if (obs !== exp_v) begin n_err++; $display("FAIL w0_store: got %h want %h", obs, exp_v); end
        txn(0, 1'b0, 4'hF, 32'h40, 32'h0, 1'b0, r_ack, r_err, r_dat, lat, r_single);
        obs = {r_ack, r_err, r_dat, r_single, 8'(lat)};
        exp_v = {1'b1, 1'b0, 32'h0BAD_F00D, 1'b1, 8'd1};
        n_checks++;
        if (obs !== exp_v) begin n_err++; $display("FAIL w0_load: got %h want %h", obs, exp_v); end
        txn(0, 1'b0, 4'hF, 32'h0000_2000, 32'h0, 1'b0, r_ack, r_err, r_dat, lat, r_single);
        obs = {r_ack, r_err, r_dat, r_single, 8'(lat)};
        exp_v = {1'b0, 1'b1, 32'h0, 1'b1, 8'd1};
        n_checks++;
        if (obs !== exp_v) begin n_err++; $display("FAIL w0_err: got %h want %h", obs, exp_v); end
    endtask

    task test_random;
        logic [31:0] a, d, m;
        logic [3:0]  s;
        bit          w;
        int          k;
        for (int which = 0; which < 2; which++) begin
            for (int p = 0; p < 8; p++) begin
                a = 32'h100 + 32'(p * 4);
                d = $urandom;
                txn(which, 1'b1, 4'hF, a, d, 1'b0, r_ack, r_err, r_dat, lat, r_single);
                mem_m[key_of(which, a)] = d;
                n_checks++;
                if ({r_ack, r_err, 8'(lat)} !== {2'b10, 8'(which + 1)}) begin
                    n_err++; $display("FAIL rnd_init dut%0d: got ack=%b err=%b lat=%0d", which, r_ack, r_err, lat);
                end
            end
            for (int n = 0; n < 40; n++) begin
                a = 32'h100 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0) a[31:12] = 20'($urandom_range(1, 20'hFFFFF));
                w = 1'($urandom);
                s = 4'($urandom);
                d = $urandom;
                txn(which, w, s, a, d, 1'b0, r_ack, r_err, r_dat, lat, r_single);
                k = key_of(which, a);
                m = (in_win(a) && !w) ? (mem_m[k] & byte_mask(s)) : 32'h0;
                exp_v = {in_win(a), !in_win(a), m, 1'b1, 8'(which + 1)};
                obs = {r_ack, r_err, r_dat, r_single, 8'(lat)};
                n_checks++;
                if (obs !== exp_v) begin
                    n_err++; $display("FAIL rnd dut%0d op%0d we=%b sel=%b adr=%h: got %h want %h",
                                      which, n, w, s, a, obs, exp_v);
                end
                if (w && in_win(a)) mem_m[k] = (mem_m[k] & ~byte_mask(s)) | (d & byte_mask(s));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
            sel[i] = '0; adr[i] = '0; dat_w[i] = '0;
        end
        test_reset();
        test_store_load();
        test_byte_lanes();
        test_decode_err();
        test_abort();
        test_reset_mid_wait();
        test_wait0();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning log2 of word depth (1024 words).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, meaning extra wait states before response, legal range 0..15.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning decode base compared against adr_i[31:ADDR_W+2].
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port cyc_i, input, 1 bit: bus cycle in progress, from the memory-stage initiator.
REQ-007 SHALL have port stb_i, input, 1 bit: request strobe.
REQ-008 SHALL have port we_i, input, 1 bit: 1 = store, 0 = load.
REQ-009 SHALL have port sel_i, input, 4 bits: byte lanes, big-endian (sel_i[3] = bits 31:24).
REQ-010 SHALL have port adr_i, input, 32 bits: byte address; bits 1:0 ignored.
REQ-011 SHALL have port dat_i, input, 32 bits: store data.
REQ-012 SHALL have port dat_o, output, 32 bits: load data.
REQ-013 SHALL have port ack_o, output, 1 bit: normal completion.
REQ-014 SHALL have port err_o, output, 1 bit: decode-error completion.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 In IDLE, a rising edge with cyc_i&stb_i=1 SHALL latch we_i, sel_i, adr_i, dat_i and go to WAIT (WAIT_CYCLES>0, counter loaded with WAIT_CYCLES-1) or RESP (WAIT_CYCLES=0).
REQ-017 In WAIT, the counter SHALL decrement each edge; at count 0 the next edge SHALL enter RESP.
REQ-018 If cyc_i=0 at any edge in WAIT, the FSM SHALL return to IDLE with no memory write and no ack_o/err_o.
REQ-019 In RESP, exactly one of ack_o/err_o SHALL be high for exactly one cycle; the next edge SHALL return to IDLE unconditionally.
REQ-020 Response latency SHALL be WAIT_CYCLES+1 edges after the sampling edge; back-to-back requests SHALL be separated by at least one IDLE cycle.
REQ-021 A latched address with adr[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2] SHALL produce err_o, no write, dat_o=0.
REQ-022 A decoded store SHALL write only the lanes with sel=1, on the edge entering RESP; sel=4'b0000 SHALL ack with no change.
REQ-023 A decoded load SHALL drive dat_o = full word at adr[ADDR_W+1:2] during RESP, with lanes where sel=0 forced to 0.
REQ-024 dat_o SHALL be 0 whenever ack_o is 0.
REQ-025 Inputs changing after the sampling edge SHALL NOT affect the transaction in progress.

Reset
REQ-026 rst=0 SHALL immediately force state IDLE, counter 0, ack_o=0, err_o=0, dat_o=0, latched request fields 0.
REQ-027 Memory contents SHALL NOT be reset; reset during WAIT SHALL abort the transaction with no write.
REQ-028 Release of rst SHALL take effect at the first rising clk edge with rst=1; no request is sampled on that edge's preceding asynchronous interval.

Structure
REQ-029 State encodings, bus widths and the byte-lane width SHALL be defined in the shared define include, not locally.
REQ-030 Storage SHALL be a sub-module dmem_ram: four byte-wide banks of 2^ADDR_W entries, synchronous per-lane write, combinational read.
REQ-031 data_mem_resp SHALL contain only FSM, wait counter, request latch, decode and output muxing.

Verification
REQ-032 WAIT_CYCLES=1: store adr=0x10, sel=1111, dat=0xDEADBEEF; then load adr=0x10 -> ack_o 2 edges after sampling, dat_o=0xDEADBEEF.
REQ-033 Byte store adr=0x10, sel=0100, dat=0x0011_2233 over 0xDEADBEEF; load sel=1111 -> dat_o=0xDE11BEEF.
REQ-034 Load adr=0x0000_1000 (outside 4 KB window, BASE_ADDR=0) -> err_o one cycle, ack_o=0, dat_o=0, memory unchanged.
REQ-035 Store adr=0x20 with cyc_i dropped during WAIT -> no ack_o/err_o, later load of 0x20 returns prior value.
REQ-036 rst pulled low mid-WAIT of a store -> outputs 0 immediately, FSM IDLE, target word unchanged.
REQ-037 WAIT_CYCLES=0: load sampled at edge N -> ack_o high in cycle after edge N+1 only, for one cycle.
